// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO registers
// Optional MULDIV_FAST_MUL_EN: single-cycle multiplies that skip the iterative path.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] Data1,
  input  logic [31:0] Data2,
  input  logic        mthi,
  input  logic        mtlo,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic        is_div;
  logic        neg_q;
  logic        neg_rem_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [63:0] acc;

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_sh;
  logic [33:0] div_diff;
  logic        div_lt;
  logic [63:0] div_next;
  logic [63:0] step_next;
  logic [31:0] res_hi, res_lo;

  // Signed ops work on magnitudes; op[0]=1 selects the unsigned variants.
  always_comb begin
    a_neg = ~op[0] & Data1[31];
    b_neg = ~op[0] & Data2[31];
    a_mag = a_neg ? (~Data1 + 32'd1) : Data1;
    b_mag = b_neg ? (~Data2 + 32'd1) : Data2;
  end

  // acc holds {partial, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? b_q : 32'd0)};
    mul_next  = {mul_sum, acc[31:1]};
    div_sh    = {acc[63:32], acc[31]};
    div_diff  = {1'b0, div_sh} - {2'b00, b_q};
    div_lt    = div_diff[33];
    div_next  = {(div_lt ? div_sh[31:0] : div_diff[31:0]), acc[30:0], ~div_lt};
    step_next = is_div ? div_next : mul_next;
  end

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    if (is_div) begin
      if (b_q == 32'd0) begin
        res_hi = a_q;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_lo = neg_q     ? (~step_next[31:0]  + 32'd1) : step_next[31:0];
        res_hi = neg_rem_q ? (~step_next[63:32] + 32'd1) : step_next[63:32];
      end
    end else begin
      {res_hi, res_lo} = neg_q ? (~step_next + 64'd1) : step_next;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fast_mag;
  logic [63:0] fast_res;
  always_comb begin
    fast_mag = {32'd0, a_mag} * {32'd0, b_mag};
    fast_res = (a_neg ^ b_neg) ? (~fast_mag + 64'd1) : fast_mag;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 5'd0;
      is_div    <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      acc       <= 64'd0;
      hi        <= 32'd0;
      lo        <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            is_div    <= op[1];
            neg_q     <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            a_q       <= Data1;
            b_q       <= b_mag;
            acc       <= {32'd0, a_mag};
            cnt       <= 5'd0;
`ifdef MULDIV_FAST_MUL_EN
            if (!op[1]) begin
              {hi, lo} <= fast_res;
              state    <= S_FIN;
            end else begin
              state    <= S_CALC;
            end
`else
            state     <= S_CALC;
`endif
          end else begin
            if (mthi) hi <= Data1;
            if (mtlo) lo <= Data1;
          end
        end
        S_CALC: begin
          acc <= step_next;
          cnt <= cnt + 5'd1;
          // Last iteration commits the corrected result straight into hi/lo.
          if (cnt == 5'd31) begin
            hi    <= res_hi;
            lo    <= res_lo;
            state <= S_FIN;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_FIN);

endmodule
